// File: rtl/cmp_pkg.sv
// Shared encodings and helpers for the serial magnitude comparator and its 2-bit slice comparator.
// Result codes are one-hot: exactly one of GT/LT/EQ is set in any legal result.
package cmp_pkg;

    localparam logic [2:0] CMP_GT = 3'b100;
    localparam logic [2:0] CMP_LT = 3'b010;
    localparam logic [2:0] CMP_EQ = 3'b001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic onehot3(input logic [2:0] v);
        return (v == CMP_GT) || (v == CMP_LT) || (v == CMP_EQ);
    endfunction

endpackage

// File: rtl/cmp2.sv
// 2-bit unsigned magnitude comparator producing a one-hot GT/LT/EQ code.
// Latency: purely combinational.
// Backpressure: none; output follows the inputs.
module cmp2
    import cmp_pkg::*;
(
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [2:0] res
);

    always_comb begin
        res = CMP_EQ;
        if (a > b) begin
            res = CMP_GT;
        end else if (a < b) begin
            res = CMP_LT;
        end
    end

endmodule

// File: rtl/serial_mag_compare.sv
// Multi-cycle WIDTH-bit magnitude compare, fed MSB slice first through an external 2-bit comparator.
// Latency: k scan cycles (first unequal slice, or NSLICE) plus one cycle before out_valid rises.
// Backpressure: one pair in flight; result held until out_ready, next pair only after that handshake.
module serial_mag_compare
    import cmp_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [1:0]       slice_a,
    output logic [1:0]       slice_b,
    input  logic [2:0]       slice_res,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_res,
    output logic             err
);

    localparam int NSLICE = WIDTH / 2;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NSLICE - 1);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_reg, b_reg;
    logic [WIDTH-1:0]  a_sh, b_sh;
    logic [IDXW-1:0]   idx;
    logic [2:0]        res_reg;
    logic              found;
    logic              err_q;
    logic              out_valid_q;

    logic              sr_ok;
    logic              sr_neq;
    logic              last;
    logic              out_fire;

    assign sr_ok    = onehot3(slice_res);
    assign sr_neq   = sr_ok && (slice_res != CMP_EQ);
    assign last     = (idx == '0);
    assign out_fire = out_valid_q && out_ready;

    assign a_sh = a_reg >> {idx, 1'b0};
    assign b_sh = b_reg >> {idx, 1'b0};

    assign out_valid = out_valid_q;
    assign out_res   = res_reg;
    assign err       = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        slice_a  = 2'b00;
        slice_b  = 2'b00;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                slice_a = a_sh[1:0];
                slice_b = b_sh[1:0];
                if ((EARLY_EXIT && sr_neq) || last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_fire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A malformed slice result only raises err; the slice is scored as equal.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg       <= '0;
            b_reg       <= '0;
            idx         <= '0;
            res_reg     <= 3'b000;
            found       <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= in_a;
                        b_reg <= in_b;
                        idx   <= IDX_TOP;
                        found <= 1'b0;
                    end
                end
                SCAN: begin
                    if (!sr_ok) begin
                        err_q <= 1'b1;
                    end
                    if (sr_neq && !found) begin
                        res_reg <= slice_res;
                        found   <= 1'b1;
                    end
                    if (last && !found && !sr_neq) begin
                        res_reg <= CMP_EQ;
                    end
                    if (!last) begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: begin
                    // out_valid rises on the cycle after DONE is entered.
                    out_valid_q <= out_valid_q ? !out_ready : 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
